bcd_updown_counter: RTL and testbench

Parametrised multi-digit BCD event counter for key-driven front-panel counting. It is driven by single-cycle pulses from the key debouncer and counts up or down within 0..MAX_VALUE, with wrap or saturate mode. It also supports synchronous clear and parallel load, and flags boundary events. Its output feeds the seven-segment display mux directly, one nibble per digit.

---
 rtl/bcd_pkg.sv | 38 +++
 rtl/bcd_digit.sv | 37 +++
 rtl/bcd_updown_counter.sv | 123 ++++++++++++
 tb/tb_bcd_updown_counter.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared BCD constants and helpers for the up/down event counter.
// MAX_VALUE is converted to a BCD constant at elaboration by to_bcd.
package bcd_pkg;

   localparam int BCD_W     = 4;
   localparam int MAX_DIGITS = 8;

   typedef enum logic [1:0] {
      OpNone,
      OpUp,
      OpDown
   } count_op_e;

   function automatic logic [31:0] to_bcd(input integer value);
      logic [31:0] r_bcd;
      integer      v;
      r_bcd = '0;
      v     = value;
      for (int i = 0; i < MAX_DIGITS; i++) begin
         r_bcd[i*BCD_W +: BCD_W] = 4'(v % 10);
         v = v / 10;
      end
      return r_bcd;
   endfunction

   // Only the low 'digits' nibbles are inspected; the rest are padding.
   function automatic logic bcd_valid(input logic [31:0] vec, input int digits);
      logic ok;
      ok = 1'b1;
      for (int i = 0; i < MAX_DIGITS; i++) begin
         if ((i < digits) && (vec[i*BCD_W +: BCD_W] > 4'd9)) begin
            ok = 1'b0;
         end
      end
      return ok;
   endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit of the ripple chain: steps up or down when enabled by the
// carry/borrow from the digit below, and wraps between 0 and i_top.
import bcd_pkg::*;

module bcd_digit (
   input  logic [BCD_W-1:0] i_digit,
   input  logic             i_up,
   input  logic             i_down,
   input  logic             i_cin,
   input  logic [BCD_W-1:0] i_top,
   output logic [BCD_W-1:0] o_digit,
   output logic             o_cout
);

   always_comb begin
      o_digit = i_digit;
      o_cout  = 1'b0;
      if (i_cin) begin
         if (i_up) begin
            if (i_digit >= i_top) begin
               o_digit = '0;
               o_cout  = 1'b1;
            end else begin
               o_digit = i_digit + 4'd1;
            end
         end else if (i_down) begin
            if (i_digit == '0) begin
               o_digit = i_top;
               o_cout  = 1'b1;
            end else begin
               o_digit = i_digit - 4'd1;
            end
         end
      end
   end

endmodule

// File: rtl/bcd_updown_counter.sv
// Multi-digit BCD up/down event counter with clear, validated load and
// wrap/saturate bound handling; flags wrap and rejected loads for one cycle.
import bcd_pkg::*;

module bcd_updown_counter #(
   parameter int unsigned DIGITS    = 2,
   parameter int unsigned MAX_VALUE = 99,
   parameter int unsigned SATURATE  = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clr,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   load_val,
   input  logic                  inc,
   input  logic                  dec,
   output logic [4*DIGITS-1:0]   cnt_out,
   output logic                  at_max,
   output logic                  at_min,
   output logic                  wrap_p,
   output logic                  load_err
);

   localparam int          W         = BCD_W * DIGITS;
   localparam logic [31:0] MAX_BCD32 = to_bcd(int'(MAX_VALUE));
   localparam logic [W-1:0] MAX_BCD  = MAX_BCD32[W-1:0];

   logic [W-1:0]  r_cnt;
   logic          r_wrap;
   logic          r_load_err;

   logic [W-1:0]  w_cnt_d;
   logic          w_wrap_d;
   logic          w_load_err_d;
   logic [W-1:0]  w_step;
   logic [DIGITS:0] w_carry;
   logic          w_up;
   logic          w_down;
   logic          w_at_max;
   logic          w_load_ok;
   count_op_e     w_op;

   // inc and dec together cancel out.
   assign w_up   = inc & ~dec;
   assign w_down = dec & ~inc;
   assign w_op   = w_up ? OpUp : (w_down ? OpDown : OpNone);

   assign w_at_max  = (r_cnt == MAX_BCD);
   assign w_load_ok = bcd_valid(32'(load_val), int'(DIGITS)) && (load_val <= MAX_BCD);

   assign w_carry[0] = w_up | w_down;

   for (genvar g = 0; g < DIGITS; g++) begin : g_digit
      bcd_digit u_digit (
         .i_digit (r_cnt[g*BCD_W +: BCD_W]),
         .i_up    (w_up),
         .i_down  (w_down),
         .i_cin   (w_carry[g]),
         .i_top   (4'd9),
         .o_digit (w_step[g*BCD_W +: BCD_W]),
         .o_cout  (w_carry[g+1])
      );
   end

   always_comb begin
      w_cnt_d      = r_cnt;
      w_wrap_d     = 1'b0;
      w_load_err_d = 1'b0;
      if (clr) begin
         w_cnt_d = '0;
      end else if (load) begin
         if (w_load_ok) begin
            w_cnt_d = load_val;
         end else begin
            w_load_err_d = 1'b1;
         end
      end else begin
         case (w_op)
            OpUp: begin
               if (w_at_max) begin
                  if (SATURATE == 0) begin
                     w_cnt_d  = '0;
                     w_wrap_d = 1'b1;
                  end
               end else begin
                  w_cnt_d = w_step;
               end
            end
            OpDown: begin
               // A borrow out of the top digit means the count was zero.
               if (w_carry[DIGITS]) begin
                  if (SATURATE == 0) begin
                     w_cnt_d  = MAX_BCD;
                     w_wrap_d = 1'b1;
                  end
               end else begin
                  w_cnt_d = w_step;
               end
            end
            default: w_cnt_d = r_cnt;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt      <= '0;
         r_wrap     <= 1'b0;
         r_load_err <= 1'b0;
      end else begin
         r_cnt      <= w_cnt_d;
         r_wrap     <= w_wrap_d;
         r_load_err <= w_load_err_d;
      end
   end

   assign cnt_out  = r_cnt;
   assign at_max   = w_at_max;
   assign at_min   = (r_cnt == '0);
   assign wrap_p   = r_wrap;
   assign load_err = r_load_err;

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Directed bench for bcd_updown_counter across four parameter sets:
// A (2,99,wrap), B (2,59,wrap), C (2,99,saturate), D (4,9999,wrap).
module tb_bcd_updown_counter;

   logic clk;
   logic rst;

   logic       clr_a, load_a, inc_a, dec_a, max_a, min_a, wrap_a, lerr_a;
   logic [7:0] lval_a, cnt_a;
   logic       clr_b, load_b, inc_b, dec_b, max_b, min_b, wrap_b, lerr_b;
   logic [7:0] lval_b, cnt_b;
   logic       clr_c, load_c, inc_c, dec_c, max_c, min_c, wrap_c, lerr_c;
   logic [7:0] lval_c, cnt_c;
   logic       clr_d, load_d, inc_d, dec_d, max_d, min_d, wrap_d, lerr_d;
   logic [15:0] lval_d, cnt_d;

   int n_assert;
   int n_fail;

   bcd_updown_counter #(.DIGITS(2), .MAX_VALUE(99), .SATURATE(0)) u_a (
      .clk(clk), .rst(rst), .clr(clr_a), .load(load_a), .load_val(lval_a), .inc(inc_a),
      .dec(dec_a), .cnt_out(cnt_a), .at_max(max_a), .at_min(min_a), .wrap_p(wrap_a),
      .load_err(lerr_a)
   );
   bcd_updown_counter #(.DIGITS(2), .MAX_VALUE(59), .SATURATE(0)) u_b (
      .clk(clk), .rst(rst), .clr(clr_b), .load(load_b), .load_val(lval_b), .inc(inc_b),
      .dec(dec_b), .cnt_out(cnt_b), .at_max(max_b), .at_min(min_b), .wrap_p(wrap_b),
      .load_err(lerr_b)
   );
   bcd_updown_counter #(.DIGITS(2), .MAX_VALUE(99), .SATURATE(1)) u_c (
      .clk(clk), .rst(rst), .clr(clr_c), .load(load_c), .load_val(lval_c), .inc(inc_c),
      .dec(dec_c), .cnt_out(cnt_c), .at_max(max_c), .at_min(min_c), .wrap_p(wrap_c),
      .load_err(lerr_c)
   );
   bcd_updown_counter #(.DIGITS(4), .MAX_VALUE(9999), .SATURATE(0)) u_d (
      .clk(clk), .rst(rst), .clr(clr_d), .load(load_d), .load_val(lval_d), .inc(inc_d),
      .dec(dec_d), .cnt_out(cnt_d), .at_max(max_d), .at_min(min_d), .wrap_p(wrap_d),
      .load_err(lerr_d)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic set_in(input int d, input logic c, input logic l, input logic i,
                         input logic dn, input logic [15:0] v);
      case (d)
         0: begin clr_a = c; load_a = l; inc_a = i; dec_a = dn; lval_a = v[7:0]; end
         1: begin clr_b = c; load_b = l; inc_b = i; dec_b = dn; lval_b = v[7:0]; end
         2: begin clr_c = c; load_c = l; inc_c = i; dec_c = dn; lval_c = v[7:0]; end
         default: begin clr_d = c; load_d = l; inc_d = i; dec_d = dn; lval_d = v; end
      endcase
   endtask

   // Drive one cycle of inputs, sample 1 time unit after the edge.
   task automatic step(input int d, input logic c, input logic l, input logic i,
                       input logic dn, input logic [15:0] v);
      set_in(d, c, l, i, dn, v);
      @(posedge clk);
      #1;
      set_in(d, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag, input int d, input logic [15:0] e_cnt,
                          input logic e_max, input logic e_min, input logic e_wrap,
                          input logic e_lerr);
      logic [15:0] c;
      logic mx, mn, wr, le;
      case (d)
         0: begin c = {8'h0, cnt_a}; mx = max_a; mn = min_a; wr = wrap_a; le = lerr_a; end
         1: begin c = {8'h0, cnt_b}; mx = max_b; mn = min_b; wr = wrap_b; le = lerr_b; end
         2: begin c = {8'h0, cnt_c}; mx = max_c; mn = min_c; wr = wrap_c; le = lerr_c; end
         default: begin c = cnt_d; mx = max_d; mn = min_d; wr = wrap_d; le = lerr_d; end
      endcase
      chk({tag, ".cnt"},      c,            e_cnt);
      chk({tag, ".at_max"},   {15'h0, mx},  {15'h0, e_max});
      chk({tag, ".at_min"},   {15'h0, mn},  {15'h0, e_min});
      chk({tag, ".wrap_p"},   {15'h0, wr},  {15'h0, e_wrap});
      chk({tag, ".load_err"}, {15'h0, le},  {15'h0, e_lerr});
   endtask

   initial begin
      n_assert = 0;
      n_fail   = 0;
      rst      = 1'b1;
      for (int d = 0; d < 4; d++) set_in(d, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
      repeat (2) @(posedge clk);
      #1;
      chk_all("rst_a", 0, 16'h00, 1'b0, 1'b1, 1'b0, 1'b0);
      chk_all("rst_b", 1, 16'h00, 1'b0, 1'b1, 1'b0, 1'b0);
      chk_all("rst_c", 2, 16'h00, 1'b0, 1'b1, 1'b0, 1'b0);
      chk_all("rst_d", 3, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);
      rst = 1'b0;

      // A: count up 12, down 13 with a wrap on the 0 -> 99 step.
      for (int k = 0; k < 12; k++) step(0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0);
      chk_all("a_up12", 0, 16'h12, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 12; k++) step(0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0);
      chk_all("a_dn12", 0, 16'h00, 1'b0, 1'b1, 1'b0, 1'b0);
      step(0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0);
      chk_all("a_dn13", 0, 16'h99, 1'b1, 1'b0, 1'b1, 1'b0);
      step(0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
      chk_all("a_idle", 0, 16'h99, 1'b1, 1'b0, 1'b0, 1'b0);

      // A: load validation and priority.
      step(0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h3A);
      chk_all("a_ld3A", 0, 16'h99, 1'b1, 1'b0, 1'b0, 1'b1);
      step(0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h45);
      chk_all("a_ld45", 0, 16'h45, 1'b0, 1'b0, 1'b0, 1'b0);
      step(0, 1'b1, 1'b1, 1'b1, 1'b0, 16'h77);
      chk_all("a_clr_pri", 0, 16'h00, 1'b0, 1'b1, 1'b0, 1'b0);
      step(0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h20);
      chk_all("a_ld_pri", 0, 16'h20, 1'b0, 1'b0, 1'b0, 1'b0);
      step(0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0);
      chk_all("a_incdec", 0, 16'h20, 1'b0, 1'b0, 1'b0, 1'b0);
      step(0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h10);
      step(0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0);
      chk_all("a_borrow", 0, 16'h09, 1'b0, 1'b0, 1'b0, 1'b0);
      step(0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0);
      chk_all("a_carry", 0, 16'h10, 1'b0, 1'b0, 1'b0, 1'b0);

      // B: MAX=59 wrap in both directions, over-max load rejected.
      step(1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h58);
      chk_all("b_ld58", 1, 16'h58, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0);
      chk_all("b_59", 1, 16'h59, 1'b1, 1'b0, 1'b0, 1'b0);
      step(1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0);
      chk_all("b_wrap", 1, 16'h00, 1'b0, 1'b1, 1'b1, 1'b0);
      step(1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
      chk_all("b_idle", 1, 16'h00, 1'b0, 1'b1, 1'b0, 1'b0);
      step(1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h60);
      chk_all("b_ld60", 1, 16'h00, 1'b0, 1'b1, 1'b0, 1'b1);
      step(1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0);
      chk_all("b_dnwrap", 1, 16'h59, 1'b1, 1'b0, 1'b1, 1'b0);

      // C: saturate holds at both bounds without wrap_p.
      step(2, 1'b0, 1'b1, 1'b0, 1'b0, 16'h99);
      chk_all("c_ld99", 2, 16'h99, 1'b1, 1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 3; k++) begin
         step(2, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0);
         chk_all($sformatf("c_sat_up%0d", k), 2, 16'h99, 1'b1, 1'b0, 1'b0, 1'b0);
      end
      step(2, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
      chk_all("c_clr", 2, 16'h00, 1'b0, 1'b1, 1'b0, 1'b0);
      step(2, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0);
      chk_all("c_sat_dn", 2, 16'h00, 1'b0, 1'b1, 1'b0, 1'b0);

      // D: four-digit ripple, full wrap, async reset between edges.
      step(3, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0999);
      chk_all("d_ld0999", 3, 16'h0999, 1'b0, 1'b0, 1'b0, 1'b0);
      step(3, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0);
      chk_all("d_ripple", 3, 16'h1000, 1'b0, 1'b0, 1'b0, 1'b0);
      step(3, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0);
      chk_all("d_borrow", 3, 16'h0999, 1'b0, 1'b0, 1'b0, 1'b0);
      step(3, 1'b0, 1'b1, 1'b0, 1'b0, 16'h9999);
      step(3, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0);
      chk_all("d_wrap", 3, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0);
      step(3, 1'b0, 1'b1, 1'b0, 1'b0, 16'h1234);
      chk_all("d_ld1234", 3, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0);
      #3;
      rst = 1'b1;
      #1;
      chk_all("d_async_rst", 3, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      step(3, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0);
      chk_all("d_post_rst", 3, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
